alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 127 ++++++++++++
 tb/tb_alu.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered ALU with one cycle of latency; o_data floats when the captured op is NOP.
// Defining ALU_OVERFLOW_FLAG_EN adds a registered signed-overflow flag for ADD/SUB.
module alu #(
    parameter int IO_BUS_WIDTH  = 32,
    parameter int CTR_BUS_WIDTH = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [CTR_BUS_WIDTH-1:0] i_ctr_code,
    input  logic [IO_BUS_WIDTH-1:0]  i_data_a,
    input  logic [IO_BUS_WIDTH-1:0]  i_data_b,
`ifdef ALU_OVERFLOW_FLAG_EN
    output logic                     o_overflow,
`endif
    output tri   [IO_BUS_WIDTH-1:0]  o_data
);

    localparam logic [CTR_BUS_WIDTH-1:0] OP_ADD  = CTR_BUS_WIDTH'(0);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_ADDU = CTR_BUS_WIDTH'(1);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SUB  = CTR_BUS_WIDTH'(2);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SUBU = CTR_BUS_WIDTH'(3);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_AND  = CTR_BUS_WIDTH'(4);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_OR   = CTR_BUS_WIDTH'(5);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_XOR  = CTR_BUS_WIDTH'(6);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_NOR  = CTR_BUS_WIDTH'(7);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SLT  = CTR_BUS_WIDTH'(8);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SLL  = CTR_BUS_WIDTH'(9);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SRL  = CTR_BUS_WIDTH'(10);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SRA  = CTR_BUS_WIDTH'(11);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SLLV = CTR_BUS_WIDTH'(12);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SRLV = CTR_BUS_WIDTH'(13);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SRAV = CTR_BUS_WIDTH'(14);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_SC_B = CTR_BUS_WIDTH'(15);

    localparam int MSB = IO_BUS_WIDTH - 1;

    // Shift amounts at or beyond the word width saturate instead of wrapping.
    function automatic logic [IO_BUS_WIDTH-1:0] shift_left(
        input logic [IO_BUS_WIDTH-1:0] a,
        input logic [IO_BUS_WIDTH-1:0] b
    );
        if (b >= IO_BUS_WIDTH) return '0;
        return a << b;
    endfunction

    function automatic logic [IO_BUS_WIDTH-1:0] shift_right_log(
        input logic [IO_BUS_WIDTH-1:0] a,
        input logic [IO_BUS_WIDTH-1:0] b
    );
        if (b >= IO_BUS_WIDTH) return '0;
        return a >> b;
    endfunction

    function automatic logic [IO_BUS_WIDTH-1:0] shift_right_arith(
        input logic [IO_BUS_WIDTH-1:0] a,
        input logic [IO_BUS_WIDTH-1:0] b
    );
        logic signed [IO_BUS_WIDTH-1:0] sa;
        sa = $signed(a);
        if (b >= IO_BUS_WIDTH) return {IO_BUS_WIDTH{a[MSB]}};
        return $unsigned(sa >>> b);
    endfunction

    logic signed [IO_BUS_WIDTH-1:0] a_s;
    logic signed [IO_BUS_WIDTH-1:0] b_s;
    logic [IO_BUS_WIDTH-1:0] sum;
    logic [IO_BUS_WIDTH-1:0] diff;
    logic                    add_ovf;
    logic                    sub_ovf;

    logic [IO_BUS_WIDTH-1:0] result_d, result_q;
    logic                    nop_d, nop_q;
    logic                    ovf_d, ovf_q;

    assign a_s  = $signed(i_data_a);
    assign b_s  = $signed(i_data_b);
    assign sum  = i_data_a + i_data_b;
    assign diff = i_data_a - i_data_b;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips away from A.
    assign add_ovf = (i_data_a[MSB] == i_data_b[MSB]) && (sum[MSB]  != i_data_a[MSB]);
    assign sub_ovf = (i_data_a[MSB] != i_data_b[MSB]) && (diff[MSB] != i_data_a[MSB]);

    always_comb begin
        result_d = '0;
        nop_d    = 1'b0;
        ovf_d    = 1'b0;
        case (i_ctr_code)
            OP_ADD:  begin result_d = sum;  ovf_d = add_ovf; end
            OP_ADDU: result_d = sum;
            OP_SUB:  begin result_d = diff; ovf_d = sub_ovf; end
            OP_SUBU: result_d = diff;
            OP_AND:  result_d = i_data_a & i_data_b;
            OP_OR:   result_d = i_data_a | i_data_b;
            OP_XOR:  result_d = i_data_a ^ i_data_b;
            OP_NOR:  result_d = ~(i_data_a | i_data_b);
            OP_SLT:  result_d = IO_BUS_WIDTH'(a_s < b_s);
            OP_SLL,  OP_SLLV: result_d = shift_left(i_data_a, i_data_b);
            OP_SRL,  OP_SRLV: result_d = shift_right_log(i_data_a, i_data_b);
            OP_SRA,  OP_SRAV: result_d = shift_right_arith(i_data_a, i_data_b);
            OP_SC_B: result_d = i_data_b;
            default: nop_d = 1'b1;
        endcase
    end

    // Result stage: one register for data, NOP marker and overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            result_q <= '0;
            nop_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            nop_q    <= nop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_data = nop_q ? {IO_BUS_WIDTH{1'bz}} : result_q;

`ifdef ALU_OVERFLOW_FLAG_EN
    assign o_overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu; o_data carries weak pull-ups so a floating bus reads all ones.
`timescale 1ns/1ps
module tb_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [4:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    wire  [W-1:0] o_data;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu #(.IO_BUS_WIDTH(W), .CTR_BUS_WIDTH(5)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_ctr_code (code),
        .i_data_a   (a),
        .i_data_b   (b),
`ifdef ALU_OVERFLOW_FLAG_EN
        .o_overflow (ovf),
`endif
        .o_data     (o_data)
    );

    for (genvar g = 0; g < W; g++) begin : g_pu
        pullup (o_data[g]);
    end

    localparam logic [W-1:0] FLOAT = 32'hFFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Apply one operation at the falling edge, then sample just after the capturing rising edge.
    task automatic run_op(input string tag, input logic [4:0] c, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] exp, input logic exp_ovf);
        @(negedge clk);
        code = c;
        a    = va;
        b    = vb;
        @(posedge clk);
        #1;
        check(tag, o_data, exp);
`ifdef ALU_OVERFLOW_FLAG_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unexpected X overflow expectation in %s", tag);
`endif
    endtask

    initial begin
        rst  = 1'b1;
        code = 5'd16;
        a    = '0;
        b    = '0;
        #1;
        check("reset_async", o_data, 32'h0);
`ifdef ALU_OVERFLOW_FLAG_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("add_wrap",  5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1);
        run_op("addu_wrap", 5'd1,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0);
        run_op("sub_neg",   5'd2,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0);
        run_op("sub_ovf",   5'd2,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1);
        run_op("subu",      5'd3,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0);
        run_op("and",       5'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        run_op("or",        5'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
        run_op("xor",       5'd6,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        run_op("nor",       5'd7,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0);
        run_op("slt_true",  5'd8,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0);
        run_op("slt_false", 5'd8,  32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0);
        run_op("srl_4",     5'd10, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0);
        run_op("sra_4",     5'd11, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
        run_op("sll_4",     5'd9,  32'h8000_0000, 32'd4,         32'h0,         1'b0);
        run_op("sra_40",    5'd11, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0);
        run_op("srl_40",    5'd10, 32'h8000_0000, 32'd40,        32'h0,         1'b0);
        run_op("sllv_31",   5'd12, 32'h1,         32'd31,        32'h8000_0000, 1'b0);
        run_op("srlv_4",    5'd13, 32'hF000_0000, 32'd4,         32'h0F00_0000, 1'b0);
        run_op("srav_pos",  5'd14, 32'h4000_0000, 32'd40,        32'h0,         1'b0);
        run_op("srav_3",    5'd14, 32'h8000_0010, 32'd3,         32'hF000_0002, 1'b0);
        run_op("sc_b",      5'd15, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 1'b0);
        run_op("nop16",     5'd16, 32'h1234_5678, 32'h0,         FLOAT,         1'b0);
        run_op("after_nop", 5'd0,  32'd2,         32'd3,         32'd5,         1'b0);
        run_op("nop31",     5'd31, 32'h0,         32'h0,         FLOAT,         1'b0);
        run_op("nop20",     5'd20, 32'h0,         32'h0,         FLOAT,         1'b0);

        // Reset while a NOP is held must drive zero, not float.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_clears_nop", o_data, 32'h0);

        // Reset during an in-flight op discards it; the next edge after release captures normally.
        @(negedge clk);
        rst = 1'b0;
        run_op("pre_reset", 5'd15, 32'h0, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        @(negedge clk);
        code = 5'd0;
        a    = 32'h7FFF_FFFF;
        b    = 32'h7FFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset", o_data, 32'h0);
        @(posedge clk);
        #1;
        check("held_reset", o_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_capture", o_data, 32'hFFFF_FFFE);
`ifdef ALU_OVERFLOW_FLAG_EN
        check("post_reset_ovf", {31'd0, ovf}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
